// File: rtl/fdc_sd_image_server.sv
// fdc_sd_image_server: answers the FDC's 512-byte SD block requests from a
// byte-wide disk-image memory, one image window per drive.
// Optional build macro FDC_SD_WRITE_EN: when defined, write requests copy the
// FDC sector buffer into the image. When undefined, writes run the full
// handshake but never touch memory, and report err (read-only image).
module fdc_sd_image_server #(
    parameter int unsigned       ADDR_W     = 20,
    parameter logic [ADDR_W-1:0] DRV0_BASE  = ADDR_W'(20'h00000),
    parameter logic [ADDR_W-1:0] DRV1_BASE  = ADDR_W'(20'h80000),
    parameter int unsigned       IMG_BLOCKS = 1024
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [31:0]       sd_lba,
    input  logic [1:0]        sd_rd,
    input  logic [1:0]        sd_wr,
    output logic              sd_ack,
    output logic [8:0]        sd_buff_addr,
    output logic [7:0]        sd_buff_dout,
    output logic              sd_buff_wr,
    input  logic [7:0]        sd_buff_din,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE, ACK, RD_REQ, RD_PUT, WR_ADDR, WR_CAP, WR_MEM, DONE
    } state_t;

    state_t      state_reg;
    logic [8:0]  idx_reg;
    logic [31:0] lba_reg;
    logic        drive_reg;
    logic        is_wr_reg;
    logic        oor_reg;

    logic [31:0]       img_blocks_c;
    logic              oor_now;
    logic [ADDR_W-1:0] base_sel;
    logic [ADDR_W-1:0] lba_off;
    logic [ADDR_W-1:0] idx_ext;

    assign img_blocks_c = 32'(IMG_BLOCKS);
    assign oor_now      = (lba_reg >= img_blocks_c);

    // Byte address only depends on registers that change while no memory
    // request is outstanding, so it is stable for the whole request.
    assign base_sel = drive_reg ? DRV1_BASE : DRV0_BASE;
    assign lba_off  = {lba_reg[ADDR_W-10:0], 9'b0};
    assign idx_ext  = {{(ADDR_W-9){1'b0}}, idx_reg};
    assign mem_addr = base_sel + lba_off + idx_ext;

    assign sd_buff_addr = idx_reg;
    assign busy         = (state_reg != IDLE);

    // Request/transfer sequencer with registered handshake and data outputs.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            lba_reg      <= '0;
            drive_reg    <= 1'b0;
            is_wr_reg    <= 1'b0;
            oor_reg      <= 1'b0;
            sd_ack       <= 1'b0;
            sd_buff_dout <= '0;
            sd_buff_wr   <= 1'b0;
            mem_rd       <= 1'b0;
            mem_wr       <= 1'b0;
            mem_wdata    <= '0;
            err          <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if ((|sd_rd) || (|sd_wr)) begin
                        lba_reg <= sd_lba;
                        idx_reg <= '0;
                        // Reads beat writes, drive 0 beats drive 1.
                        if (sd_rd[0]) begin
                            drive_reg <= 1'b0;
                            is_wr_reg <= 1'b0;
                        end else if (sd_rd[1]) begin
                            drive_reg <= 1'b1;
                            is_wr_reg <= 1'b0;
                        end else if (sd_wr[0]) begin
                            drive_reg <= 1'b0;
                            is_wr_reg <= 1'b1;
                        end else begin
                            drive_reg <= 1'b1;
                            is_wr_reg <= 1'b1;
                        end
                        state_reg <= ACK;
                    end
                end
                ACK: begin
                    sd_ack  <= 1'b1;
                    oor_reg <= oor_now;
                    if (is_wr_reg) begin
                        state_reg <= WR_ADDR;
                    end else begin
                        // Out-of-range reads never issue a memory request.
                        mem_rd    <= !oor_now;
                        state_reg <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (oor_reg) begin
                        sd_buff_dout <= 8'h00;
                        sd_buff_wr   <= 1'b1;
                        state_reg    <= RD_PUT;
                    end else if (mem_ready) begin
                        mem_rd       <= 1'b0;
                        sd_buff_dout <= mem_rdata;
                        sd_buff_wr   <= 1'b1;
                        state_reg    <= RD_PUT;
                    end
                end
                RD_PUT: begin
                    sd_buff_wr <= 1'b0;
                    if (idx_reg == 9'd511) begin
                        err       <= oor_reg;
                        state_reg <= DONE;
                    end else begin
                        idx_reg   <= idx_reg + 9'd1;
                        mem_rd    <= !oor_reg;
                        state_reg <= RD_REQ;
                    end
                end
                WR_ADDR: begin
                    // sd_buff_addr is presented this cycle; data arrives next.
                    state_reg <= WR_CAP;
                end
                WR_CAP: begin
                    mem_wdata <= sd_buff_din;
`ifdef FDC_SD_WRITE_EN
                    mem_wr    <= !oor_reg;
                    state_reg <= WR_MEM;
`else
                    if (idx_reg == 9'd511) begin
                        err       <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        idx_reg   <= idx_reg + 9'd1;
                        state_reg <= WR_ADDR;
                    end
`endif
                end
`ifdef FDC_SD_WRITE_EN
                WR_MEM: begin
                    if (oor_reg || mem_ready) begin
                        mem_wr <= 1'b0;
                        if (idx_reg == 9'd511) begin
                            err       <= oor_reg;
                            state_reg <= DONE;
                        end else begin
                            idx_reg   <= idx_reg + 9'd1;
                            state_reg <= WR_ADDR;
                        end
                    end
                end
`endif
                DONE: begin
                    sd_ack    <= 1'b0;
                    err       <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fdc_sd_image_server.sv
// tb_fdc_sd_image_server: directed bench for fdc_sd_image_server with a
// wait-state-configurable image memory and a registered-read FDC buffer.
// Honours FDC_SD_WRITE_EN for the expected write-path behaviour.
module tb_fdc_sd_image_server;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic [31:0] sd_lba = '0;
    logic [1:0]  sd_rd = '0;
    logic [1:0]  sd_wr = '0;
    logic        sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic        sd_buff_wr;
    logic [7:0]  sd_buff_din = '0;
    logic [19:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    logic        busy;
    logic        err;

    fdc_sd_image_server dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy), .err(err)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Image content seen by reads: fixed function of the byte address.
    function automatic logic [7:0] img_byte(input logic [19:0] a);
        return a[7:0] ^ a[15:8] ^ {a[19:16], 4'h9};
    endfunction

    // Memory model: ready after wait_n extra cycles of a held request.
    int wait_n = 0;
    int wcnt = 0;
    logic [7:0] wmem [0:(1<<20)-1];
    assign mem_ready = (mem_rd | mem_wr) && (wcnt == wait_n);
    assign mem_rdata = img_byte(mem_addr);

    always @(posedge wb_clk_i) begin
        if ((mem_rd | mem_wr) && !mem_ready) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (mem_wr && mem_ready) wmem[mem_addr] <= mem_wdata;
    end

    // FDC sector buffer: registered read, pattern addr ^ A5.
    always @(posedge wb_clk_i) sd_buff_din <= sd_buff_addr[7:0] ^ 8'hA5;

    int n_cmp = 0;
    int n_bad = 0;
    int ack_cyc, ack_delay, pulses, dout_bad, baddr_bad;
    int rd_cyc, wr_cyc, err_cyc, maddr_bad, stab_bad, nacc;
    logic [31:0] first_maddr;
    bit timeout;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one transfer, sampling on falling edges, until busy drops.
    task automatic run_txn(input bit apply, input logic [1:0] rd, input logic [1:0] wr,
                           input logic [31:0] lba, input logic [1:0] drop_rd,
                           input logic [1:0] drop_wr, input logic [19:0] base,
                           input int abort_at);
        logic [19:0] a_exp;
        logic [7:0]  d_exp;
        logic [19:0] prev_addr;
        bit seen_ack, prev_req, oor;
        ack_cyc = 0; ack_delay = 0; pulses = 0; dout_bad = 0; baddr_bad = 0;
        rd_cyc = 0; wr_cyc = 0; err_cyc = 0; maddr_bad = 0; stab_bad = 0; nacc = 0;
        first_maddr = 32'hFFFF_FFFF;
        timeout = 1'b1; seen_ack = 1'b0; prev_req = 1'b0; prev_addr = '0;
        oor = (lba >= 32'd1024);
        if (apply) begin
            sd_rd = rd; sd_wr = wr; sd_lba = lba;
        end
        for (int n = 1; n <= 6000; n++) begin
            @(negedge wb_clk_i);
            if (sd_ack) begin
                ack_cyc++;
                if (!seen_ack) begin
                    seen_ack = 1'b1;
                    ack_delay = n;
                    sd_rd = sd_rd & ~drop_rd;
                    sd_wr = sd_wr & ~drop_wr;
                end
            end
            if (err) err_cyc++;
            if (mem_rd) rd_cyc++;
            if (mem_wr) wr_cyc++;
            if ((mem_rd || mem_wr) && prev_req && (mem_addr != prev_addr)) stab_bad++;
            prev_req = mem_rd || mem_wr;
            prev_addr = mem_addr;
            if ((mem_rd || mem_wr) && mem_ready) begin
                a_exp = base + 20'(lba << 9) + 20'(nacc);
                if (first_maddr == 32'hFFFF_FFFF) first_maddr = 32'(mem_addr);
                if (mem_addr != a_exp) maddr_bad++;
                nacc++;
            end
            if (sd_buff_wr) begin
                a_exp = base + 20'(lba << 9) + 20'(pulses);
                d_exp = oor ? 8'h00 : img_byte(a_exp);
                if (sd_buff_addr != 9'(pulses)) baddr_bad++;
                if (sd_buff_dout != d_exp) dout_bad++;
                pulses++;
                if (pulses == abort_at) begin
                    timeout = 1'b0;
                    return;
                end
            end
            if (seen_ack && !busy) begin
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic report(input string name);
        $display("txn %s: ack_delay=%0d ack=%0d pulses=%0d mem_rd=%0d mem_wr=%0d err=%0d first_addr=%0h",
                 name, ack_delay, ack_cyc, pulses, rd_cyc, wr_cyc, err_cyc, first_maddr);
        check({name, "_timeout"}, 32'(timeout), 32'd0);
    endtask

    int wbad;

    initial begin
        // Reset state.
        repeat (3) @(negedge wb_clk_i);
        check("rst_ctrl", {26'd0, sd_ack, busy, mem_rd, mem_wr, sd_buff_wr, err}, 32'd0);
        check("rst_maddr", 32'(mem_addr), 32'd0);
        check("rst_baddr", 32'(sd_buff_addr), 32'd0);
        wb_rst_i = 1'b0;

        // Read drive 0, LBA 3, zero-wait memory.
        run_txn(1'b1, 2'b01, 2'b00, 32'd3, 2'b01, 2'b00, 20'h00000, 0);
        report("rd0_lba3");
        check("rd0_ack_delay", 32'(ack_delay), 32'd2);
        check("rd0_ack_cycles", 32'(ack_cyc), 32'd1025);
        check("rd0_pulses", 32'(pulses), 32'd512);
        check("rd0_baddr_bad", 32'(baddr_bad), 32'd0);
        check("rd0_dout_bad", 32'(dout_bad), 32'd0);
        check("rd0_mem_rd", 32'(rd_cyc), 32'd512);
        check("rd0_first_addr", first_maddr, 32'h00600);
        check("rd0_maddr_bad", 32'(maddr_bad), 32'd0);
        check("rd0_err", 32'(err_cyc), 32'd0);

        // Write drive 1, LBA 0.
        run_txn(1'b1, 2'b00, 2'b10, 32'd0, 2'b00, 2'b10, 20'h80000, 0);
        report("wr1_lba0");
        check("wr1_pulses", 32'(pulses), 32'd0);
        check("wr1_mem_rd", 32'(rd_cyc), 32'd0);
`ifdef FDC_SD_WRITE_EN
        check("wr1_ack_cycles", 32'(ack_cyc), 32'd1537);
        check("wr1_mem_wr", 32'(wr_cyc), 32'd512);
        check("wr1_first_addr", first_maddr, 32'h80000);
        check("wr1_maddr_bad", 32'(maddr_bad), 32'd0);
        check("wr1_err", 32'(err_cyc), 32'd0);
        wbad = 0;
        for (int i = 0; i < 512; i++) begin
            if (wmem[20'h80000 + 20'(i)] != (8'(i) ^ 8'hA5)) wbad++;
        end
        check("wr1_image_bad", 32'(wbad), 32'd0);
`else
        check("wr1_ack_cycles", 32'(ack_cyc), 32'd1025);
        check("wr1_mem_wr", 32'(wr_cyc), 32'd0);
        check("wr1_err", 32'(err_cyc), 32'd1);
`endif

        // Priority: rd=11, wr=01 together; each served in turn while held.
        run_txn(1'b1, 2'b11, 2'b01, 32'd2, 2'b01, 2'b00, 20'h00000, 0);
        report("prio_a");
        check("prio_a_pulses", 32'(pulses), 32'd512);
        check("prio_a_first_addr", first_maddr, 32'h00400);
        check("prio_a_dout_bad", 32'(dout_bad), 32'd0);
        run_txn(1'b0, 2'b00, 2'b00, 32'd2, 2'b10, 2'b00, 20'h80000, 0);
        report("prio_b");
        check("prio_b_ack_delay", 32'(ack_delay), 32'd2);
        check("prio_b_pulses", 32'(pulses), 32'd512);
        check("prio_b_first_addr", first_maddr, 32'h80400);
        check("prio_b_dout_bad", 32'(dout_bad), 32'd0);
        run_txn(1'b0, 2'b00, 2'b00, 32'd2, 2'b00, 2'b01, 20'h00000, 0);
        report("prio_c");
        check("prio_c_pulses", 32'(pulses), 32'd0);
        check("prio_c_mem_rd", 32'(rd_cyc), 32'd0);
`ifdef FDC_SD_WRITE_EN
        check("prio_c_first_addr", first_maddr, 32'h00400);
        check("prio_c_mem_wr", 32'(wr_cyc), 32'd512);
`else
        check("prio_c_err", 32'(err_cyc), 32'd1);
        check("prio_c_ack_cycles", 32'(ack_cyc), 32'd1025);
`endif
        repeat (3) @(negedge wb_clk_i);
        check("prio_idle_after", {30'd0, busy, sd_ack}, 32'd0);

        // Out-of-range LBA 1024 read.
        run_txn(1'b1, 2'b01, 2'b00, 32'd1024, 2'b01, 2'b00, 20'h00000, 0);
        report("rd_oor");
        check("oor_pulses", 32'(pulses), 32'd512);
        check("oor_dout_bad", 32'(dout_bad), 32'd0);
        check("oor_mem_rd", 32'(rd_cyc), 32'd0);
        check("oor_err", 32'(err_cyc), 32'd1);
        check("oor_ack_cycles", 32'(ack_cyc), 32'd1025);

        // Last valid block of drive 1.
        run_txn(1'b1, 2'b10, 2'b00, 32'd1023, 2'b10, 2'b00, 20'h80000, 0);
        report("rd1_lba1023");
        check("top_first_addr", first_maddr, 32'hFFE00);
        check("top_dout_bad", 32'(dout_bad), 32'd0);
        check("top_err", 32'(err_cyc), 32'd0);

        // Three wait cycles per memory access.
        wait_n = 3;
        run_txn(1'b1, 2'b10, 2'b00, 32'd5, 2'b10, 2'b00, 20'h80000, 0);
        report("rd1_wait3");
        check("wait_ack_cycles", 32'(ack_cyc), 32'd2561);
        check("wait_mem_rd", 32'(rd_cyc), 32'd2048);
        check("wait_stab_bad", 32'(stab_bad), 32'd0);
        check("wait_dout_bad", 32'(dout_bad), 32'd0);
        check("wait_maddr_bad", 32'(maddr_bad), 32'd0);
        wait_n = 0;

        // Reset in the middle of a read, then a fresh request.
        run_txn(1'b1, 2'b01, 2'b00, 32'd7, 2'b01, 2'b00, 20'h00000, 100);
        report("rd0_abort");
        @(negedge wb_clk_i);
        check("abort_pre_mem_rd", 32'(mem_rd), 32'd1);
        wb_rst_i = 1'b1;
        #1;
        check("abort_ctrl", {29'd0, sd_ack, mem_rd, busy}, 32'd0);
        check("abort_baddr", 32'(sd_buff_addr), 32'd0);
        repeat (2) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        run_txn(1'b1, 2'b01, 2'b00, 32'd7, 2'b01, 2'b00, 20'h00000, 0);
        report("rd0_restart");
        check("restart_pulses", 32'(pulses), 32'd512);
        check("restart_baddr_bad", 32'(baddr_bad), 32'd0);
        check("restart_first_addr", first_maddr, 32'h00E00);
        check("restart_dout_bad", 32'(dout_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
